cpu_clock_controller: RTL
=========================

CPU_CLOCK_CONTROLLER -- requirements
Module: cpu_clock_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a button edge is accepted.
REQ-002 Parameter START_RUNNING, default 0, state entered on reset release (0 = HALTED, 1 = RUNNING).
REQ-003 clock_100mhz  input  1  sole clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rate_select  input  5  divide exponent R; tick period = 2^(R+1) clock_100mhz cycles.
REQ-006 btn_run  input  1  raw, asynchronous run/halt toggle button, active-high.
REQ-007 btn_step  input  1  raw, asynchronous single-step button, active-high.
REQ-008 halt_req  input  1  synchronous level from the CPU (breakpoint/halt instruction); forces halt.
REQ-009 cpu_clock_enable  output  1  one-cycle pulse; the CPU advances exactly one step per pulse.
REQ-010 running  output  1  high in RUNNING state.
REQ-011 step_count  output  32  number of cpu_clock_enable pulses issued since reset.

Function
REQ-012 btn_run and btn_step shall each pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-013 Only debounced rising edges shall act, as one-cycle events run_ev and step_ev; held buttons produce no repeats.
REQ-014 FSM states: HALTED, RUNNING, STEPPING.
REQ-015 HALTED: run_ev and halt_req low -> RUNNING; otherwise step_ev -> STEPPING; otherwise stay.
REQ-016 STEPPING: assert cpu_clock_enable for exactly that one cycle, then -> HALTED unconditionally.
REQ-017 RUNNING: run_ev or halt_req high -> HALTED next cycle with no enable pulse in the transition cycle; step_ev ignored.
REQ-018 In HALTED, run_ev with halt_req high shall be ignored.
REQ-019 In HALTED, run_ev and step_ev in the same cycle: run wins, step_ev dropped.
REQ-020 Prescaler: 33-bit counter, cleared on entering RUNNING; in RUNNING it increments each cycle; at count = 2^(R+1)-1 it pulses cpu_clock_enable and clears.
REQ-021 R shall be latched on entering RUNNING and at each tick; a rate_select change mid-period takes effect from the next period.
REQ-022 First tick after entering RUNNING occurs 2^(R+1) cycles after the entry cycle.
REQ-023 R=0: a pulse every 2nd cycle; R=31: period 2^32, no counter overflow.
REQ-024 step_count increments by 1 per cpu_clock_enable pulse and wraps from 0xFFFFFFFF to 0.
REQ-025 cpu_clock_enable shall never be high in two consecutive cycles.
REQ-026 cpu_clock_enable and running shall be registered outputs.

Reset
REQ-027 While reset is low: state = HALTED (or RUNNING if START_RUNNING=1), cpu_clock_enable=0, running=START_RUNNING, step_count=0, prescaler=0, synchronizers and debouncers = 0 (released level).
REQ-028 Reset asserted mid-period or mid-step shall abort immediately; no pulse is emitted in the reset-release cycle.
REQ-029 A button held through reset release shall produce no event until released and pressed again.

Structure
REQ-030 Package peripherals shall hold the clock_state_t enum (HALTED, RUNNING, STEPPING) and the rate_select width constant.
REQ-031 Sub-module button_debouncer (synchronizer, debounce counter, rising-edge pulse, DEBOUNCE_CYCLES parameter) shall be instantiated once per button.
REQ-032 The top level shall drive the CPU with clock_100mhz plus cpu_clock_enable instead of a derived clock.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset, START_RUNNING=0, press btn_step 10 cycles -> exactly one enable pulse, step_count=1, running=0.
REQ-034 rate_select=2, press btn_run -> running=1, pulses 8 cycles apart, first pulse 8 cycles after entry; after 5 pulses step_count=5.
REQ-035 RUNNING, R=3, change rate_select to 0 mid-period -> current 16-cycle period completes, then pulses every 2 cycles.
REQ-036 RUNNING, halt_req high 1 cycle -> running=0 next cycle, no further pulses; btn_run while halt_req high -> stays HALTED.
REQ-037 btn_step with 3-cycle glitches -> no event; btn_run and btn_step debounced in the same cycle from HALTED -> RUNNING, no step pulse.
REQ-038 Preload step_count 0xFFFFFFFF (force), one step -> step_count=0; reset asserted mid-period -> outputs at reset values, no pulse on reset release.

Source files
------------

// File: rtl/cpu_clock_controller_pkg.sv
// Shared types for the CPU clock controller.
// Holds the controller state enum, rate width and period helper.
package peripherals;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STEPPING = 2'd2
  } clock_state_t;

  localparam int RATE_W  = 5;
  localparam int PRESC_W = 33;

  // Terminal prescaler count for exponent r: 2^(r+1)-1.
  // 33 bits hold 2^32 for r=31 without overflow.
  function automatic logic [PRESC_W-1:0] presc_term(
    input logic [RATE_W-1:0] r
  );
    return (PRESC_W'(2) << r) - PRESC_W'(1);
  endfunction

endpackage

// File: rtl/cpu_clock_controller_debouncer.sv
// Button synchronizer + debouncer + rising-edge event.
// Ports: i_clk, i_rst_n, i_btn (raw async), o_rise (1-cycle event).
module button_debouncer
  import peripherals::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_sample;
  logic          w_hit;

  assign w_sample = r_sync[1];
  assign w_hit    = (w_sample != r_level)
                 && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign o_rise   = r_rise;

  // r_armed stays low until a real released sample is seen,
  // so a button held through reset gives no event.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_armed <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_vld  <= {r_vld[0], 1'b1};
      if (r_vld[1] && !w_sample)
        r_armed <= 1'b1;
      if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_cnt   <= '0;
        r_level <= w_sample;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_rise <= w_hit && w_sample && r_armed;
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// Run/halt/step controller producing a CPU clock-enable pulse.
// Ports: clock_100mhz, reset(n), rate_select, btn_run, btn_step,
//   halt_req in; cpu_clock_enable, running, step_count out.
module cpu_clock_controller
  import peripherals::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit START_RUNNING   = 1'b0
) (
  input  logic              clock_100mhz,
  input  logic              reset,
  input  logic [RATE_W-1:0] rate_select,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              halt_req,
  output logic              cpu_clock_enable,
  output logic              running,
  output logic [31:0]       step_count
);

  localparam clock_state_t RST_STATE =
    START_RUNNING ? RUNNING : HALTED;

  clock_state_t       r_state;
  clock_state_t       w_next;
  logic [PRESC_W-1:0] r_presc;
  logic [RATE_W-1:0]  r_rate;
  logic               r_en;
  logic               r_running;
  logic [31:0]        r_step_count;
  logic               w_run_ev;
  logic               w_step_ev;
  logic               w_enter;
  logic               w_tick;
  logic               w_en_nxt;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_run (
    .i_clk  (clock_100mhz),
    .i_rst_n(reset),
    .i_btn  (btn_run),
    .o_rise (w_run_ev)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_step (
    .i_clk  (clock_100mhz),
    .i_rst_n(reset),
    .i_btn  (btn_step),
    .o_rise (w_step_ev)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HALTED: begin
        // Run beats step when both arrive together.
        if (w_run_ev && !halt_req)
          w_next = RUNNING;
        else if (w_step_ev)
          w_next = STEPPING;
      end
      RUNNING: begin
        if (w_run_ev || halt_req)
          w_next = HALTED;
      end
      STEPPING: w_next = HALTED;
      default:  w_next = HALTED;
    endcase
  end

  assign w_enter  = (r_state != RUNNING) && (w_next == RUNNING);
  // No tick in a cycle that is leaving RUNNING.
  assign w_tick   = (r_state == RUNNING) && (w_next == RUNNING)
                 && (r_presc == presc_term(r_rate));
  assign w_en_nxt = (w_next == STEPPING) || w_tick;

  always_ff @(posedge clock_100mhz or negedge reset) begin
    if (!reset) begin
      r_state      <= RST_STATE;
      r_presc      <= '0;
      r_rate       <= '0;
      r_en         <= 1'b0;
      r_running    <= START_RUNNING;
      r_step_count <= '0;
    end else begin
      r_state   <= w_next;
      r_en      <= w_en_nxt;
      r_running <= (w_next == RUNNING);
      if (w_enter || w_tick) begin
        r_presc <= '0;
        r_rate  <= rate_select;
      end else if (r_state == RUNNING) begin
        r_presc <= r_presc + PRESC_W'(1);
      end
      if (w_en_nxt)
        r_step_count <= r_step_count + 32'd1;
    end
  end

  assign cpu_clock_enable = r_en;
  assign running          = r_running;
  assign step_count       = r_step_count;

endmodule
